// File: rtl/fb_pkg.sv
// Shared constants and types for the LED frame-buffer write path.
package fb_pkg;

    localparam int FB_ADDR_W = 12;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 4096;

    // IDLE: no fill pending. FILL: a bulk fill is pending.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Bundle of the stream handshake, fill command and memory port A signals.
// master = request side (stream source / fill requester), slave = scheduler.
interface fb_write_scheduler_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
);
    logic              stream_valid;
    logic              stream_ready;
    logic [ADDR_W-1:0] stream_addr;
    logic [DATA_W-1:0] stream_data;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_count;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] address_a;
    logic [DATA_W-1:0] data_in_a;
    logic              wr_a;
    logic              clock_en_a;

    modport slave (
        input  stream_valid, stream_addr, stream_data,
        input  fill_start, fill_base, fill_count, fill_value,
        output stream_ready, fill_busy, fill_done,
        output address_a, data_in_a, wr_a, clock_en_a
    );

    modport master (
        output stream_valid, stream_addr, stream_data,
        output fill_start, fill_base, fill_count, fill_value,
        input  stream_ready, fill_busy, fill_done,
        input  address_a, data_in_a, wr_a, clock_en_a
    );
endinterface

// File: rtl/fb_fill_counter.sv
// Fill address / remaining-byte tracker for the bulk-fill engine.
// The address wraps naturally at 2^ADDR_W; remaining is one bit wider so
// a full-memory fill (2^ADDR_W bytes) can be expressed.
module fb_fill_counter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   remaining_reg;

    // Load a new fill range, or advance by one byte per issued fill write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            addr_reg      <= base;
            remaining_reg <= count;
        end else if (step) begin
            addr_reg      <= addr_reg + ADDR_W'(1);
            remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
        end
    end

    assign addr = addr_reg;
    assign last = (remaining_reg == (ADDR_W+1)'(1));
endmodule

// File: rtl/fb_write_scheduler.sv
// Owns write port A of the frame buffer. Each cycle issues at most one
// write: a stream byte (priority) or a fill byte. After MAX_STREAM_RUN
// consecutive stream grants with a fill pending, the stream is held off
// for one cycle so the fill makes progress. Port A outputs are registered.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int ADDR_W         = FB_ADDR_W,
    parameter int DATA_W         = FB_DATA_W,
    parameter int MAX_STREAM_RUN = 7
) (
    input logic                clk,
    input logic                rst,
    fb_write_scheduler_if.slave bus
);
    localparam logic [7:0] RUN_LIMIT = 8'(MAX_STREAM_RUN);

    fb_state_t         state_reg, state_next;
    logic [7:0]        run_cnt_reg, run_cnt_next;
    logic [ADDR_W-1:0] address_reg, address_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              wr_reg, wr_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] fill_value_reg, fill_value_next;

    logic              accept;
    logic              load;
    logic              step;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_last;

    fb_fill_counter #(.ADDR_W(ADDR_W)) u_fill_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .base  (bus.fill_base),
        .count (bus.fill_count),
        .addr  (fill_addr),
        .last  (fill_last)
    );

    // Stream is only held off when a fill is pending and its run is exhausted
    assign bus.stream_ready = !((state_reg == FILL) && (run_cnt_reg == RUN_LIMIT));
    assign accept           = bus.stream_valid && bus.stream_ready;

    // Register state, run counter and all port A / status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            run_cnt_reg    <= '0;
            address_reg    <= '0;
            data_reg       <= '0;
            wr_reg         <= 1'b0;
            done_reg       <= 1'b0;
            fill_value_reg <= '0;
        end else begin
            state_reg      <= state_next;
            run_cnt_reg    <= run_cnt_next;
            address_reg    <= address_next;
            data_reg       <= data_next;
            wr_reg         <= wr_next;
            done_reg       <= done_next;
            fill_value_reg <= fill_value_next;
        end
    end

    // Arbitrate the write slot and handle fill start / completion
    always_comb begin
        state_next      = state_reg;
        run_cnt_next    = run_cnt_reg;
        address_next    = address_reg;
        data_next       = data_reg;
        wr_next         = 1'b0;
        done_next       = 1'b0;
        fill_value_next = fill_value_reg;
        load            = 1'b0;
        step            = 1'b0;

        if (accept) begin
            address_next = bus.stream_addr;
            data_next    = bus.stream_data;
            wr_next      = 1'b1;
            if (state_reg == FILL) begin
                run_cnt_next = run_cnt_reg + 8'd1;
            end
        end else if (state_reg == FILL) begin
            address_next = fill_addr;
            data_next    = fill_value_reg;
            wr_next      = 1'b1;
            step         = 1'b1;
            run_cnt_next = '0;
            if (fill_last) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end

        // A fill command is only taken when no fill is pending
        if ((state_reg == IDLE) && bus.fill_start) begin
            if (bus.fill_count != '0) begin
                load            = 1'b1;
                fill_value_next = bus.fill_value;
                state_next      = FILL;
                run_cnt_next    = '0;
            end else begin
                done_next = 1'b1;
            end
        end
    end

    assign bus.address_a  = address_reg;
    assign bus.data_in_a  = data_reg;
    assign bus.wr_a       = wr_reg;
    assign bus.clock_en_a = wr_reg;
    assign bus.fill_busy  = (state_reg == FILL);
    assign bus.fill_done  = done_reg;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Randomised and directed bench for fb_write_scheduler against a
// transaction-level model of the write-slot rules.
module tb_fb_write_scheduler;
    import fb_pkg::*;

    localparam int MAX_RUN = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_write_scheduler_if #(.ADDR_W(FB_ADDR_W), .DATA_W(FB_DATA_W)) bus ();

    fb_write_scheduler #(
        .ADDR_W(FB_ADDR_W), .DATA_W(FB_DATA_W), .MAX_STREAM_RUN(MAX_RUN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model of the pending fill and the expected port A contents
    bit         m_busy;
    int         m_next, m_left, m_streak, m_writes, m_base, m_count;
    logic [7:0] m_value;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
    bit          e_wr, e_done;
    int          ready_low_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_next = 0; m_left = 0; m_streak = 0; m_writes = 0;
        e_addr = '0; e_data = '0; e_wr = 0; e_done = 0;
    endtask

    task automatic drive(input logic sv, input logic [11:0] sa, input logic [7:0] sd,
                         input logic fs, input logic [11:0] fb, input logic [12:0] fc,
                         input logic [7:0] fv);
        bus.stream_valid = sv; bus.stream_addr = sa; bus.stream_data = sd;
        bus.fill_start = fs; bus.fill_base = fb; bus.fill_count = fc; bus.fill_value = fv;
    endtask

    task automatic drive_idle();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 13'h0, 8'h0);
    endtask

    // One clock: called just after a falling edge with inputs applied
    task automatic tick();
        bit ready, acc, was_busy;
        #1;
        ready = !(m_busy && m_streak == MAX_RUN);
        check_val("stream_ready", bus.stream_ready, ready);
        if (!bus.stream_ready) ready_low_cnt++;
        acc = bus.stream_valid && ready;
        was_busy = m_busy;
        e_done = 0;
        if (acc) begin
            e_wr = 1; e_addr = bus.stream_addr; e_data = bus.stream_data;
            if (m_busy) m_streak++;
        end else if (m_busy) begin
            e_wr = 1; e_addr = m_next[11:0]; e_data = m_value;
            m_next = (m_next + 1) % FB_DEPTH;
            m_left--; m_streak = 0; m_writes++;
            if (m_left == 0) begin
                m_busy = 0; e_done = 1;
                $display("fill base=0x%03h count=%0d value=0x%02h complete, %0d writes",
                         m_base, m_count, m_value, m_writes);
            end
        end else begin
            e_wr = 0;
        end
        if (bus.fill_start && !was_busy) begin
            if (bus.fill_count != 0) begin
                m_busy = 1; m_next = bus.fill_base; m_left = bus.fill_count;
                m_value = bus.fill_value; m_streak = 0; m_writes = 0;
                m_base = bus.fill_base; m_count = bus.fill_count;
            end else begin
                e_done = 1;
                $display("fill with zero count, done only");
            end
        end
        @(posedge clk);
        #1;
        check_val("wr_a", bus.wr_a, e_wr);
        check_val("clock_en_a", bus.clock_en_a, e_wr);
        check_val("address_a", bus.address_a, e_addr);
        check_val("data_in_a", bus.data_in_a, e_data);
        check_val("fill_done", bus.fill_done, e_done);
        check_val("fill_busy", bus.fill_busy, m_busy);
        @(negedge clk);
    endtask

    task automatic run_fill(input logic [11:0] fb, input logic [12:0] fc, input logic [7:0] fv);
        drive(1'b0, 12'h0, 8'h0, 1'b1, fb, fc, fv);
        tick();
        drive_idle();
        for (int i = 0; i < 5000 && m_busy; i++) tick();
        check_val("fill_finished", bus.fill_busy, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_wr_a", bus.wr_a, 1'b0);
        check_val("rst_clock_en_a", bus.clock_en_a, 1'b0);
        check_val("rst_address_a", bus.address_a, 12'h0);
        check_val("rst_data_in_a", bus.data_in_a, 8'h0);
        check_val("rst_fill_busy", bus.fill_busy, 1'b0);
        check_val("rst_fill_done", bus.fill_done, 1'b0);
        check_val("rst_stream_ready", bus.stream_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Stream-only writes
        drive(1'b1, 12'h010, 8'hA1, 1'b0, 12'h0, 13'h0, 8'h0); tick();
        $display("stream write addr=0x010 data=0xA1");
        drive(1'b1, 12'h011, 8'hA2, 1'b0, 12'h0, 13'h0, 8'h0); tick();
        $display("stream write addr=0x011 data=0xA2");
        drive(1'b1, 12'hFFF, 8'hA3, 1'b0, 12'h0, 13'h0, 8'h0); tick();
        $display("stream write addr=0xFFF data=0xA3");
        drive_idle(); tick(); tick();

        // Plain, wrapping, zero-length and full-memory fills
        run_fill(12'h100, 13'd4, 8'h5A);
        run_fill(12'hFFE, 13'd4, 8'h77);
        run_fill(12'h123, 13'd0, 8'h99);
        run_fill(12'h800, 13'd4096, 8'h3C);

        // Starvation guard: fill of 2 with the stream held valid
        ready_low_cnt = 0;
        drive(1'b1, 12'h050, 8'h11, 1'b1, 12'h400, 13'd2, 8'hC3);
        tick();
        for (int i = 0; i < 60 && m_busy; i++) begin
            drive(1'b1, 12'($urandom), 8'($urandom), 1'b0, 12'h0, 13'h0, 8'h0);
            tick();
        end
        check_val("starve_ready_low", ready_low_cnt, 2);
        check_val("starve_busy_end", bus.fill_busy, 1'b0);
        drive_idle(); tick();

        // FillStart while busy is ignored
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h300, 13'd5, 8'h33); tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h700, 13'd9, 8'hEE); tick();
        drive_idle();
        for (int i = 0; i < 20 && m_busy; i++) tick();
        check_val("ignore_restart_busy", bus.fill_busy, 1'b0);
        tick();

        // Reset after 2 of 10 fill writes
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h200, 13'd10, 8'h6B); tick();
        drive_idle(); tick(); tick();
        rst = 1'b1;
        #1;
        check_val("midrst_wr_a", bus.wr_a, 1'b0);
        check_val("midrst_fill_busy", bus.fill_busy, 1'b0);
        check_val("midrst_fill_done", bus.fill_done, 1'b0);
        check_val("midrst_address_a", bus.address_a, 12'h0);
        $display("reset asserted mid-fill after 2 writes");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(); tick();
        run_fill(12'h0F0, 13'd3, 8'h42);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        sv, fs;
            logic [12:0] fc;
            int          r;
            sv = ($urandom_range(0, 9) < 7);
            fs = ($urandom_range(0, 29) == 0);
            r  = $urandom_range(0, 9);
            if (r == 0)      fc = 13'd0;
            else if (r == 1) fc = 13'($urandom_range(100, 300));
            else             fc = 13'($urandom_range(1, 24));
            drive(sv, 12'($urandom), 8'($urandom), fs, 12'($urandom), fc, 8'($urandom));
            tick();
        end
        drive_idle();
        for (int i = 0; i < 400 && m_busy; i++) tick();
        check_val("drain_fill_busy", bus.fill_busy, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
